// File: rtl/norm2_driver.sv
// norm2_driver: streams N samples into an accelerator array, launches the accelerator and returns its result.
// Optional readback checksum of the loaded array: define NORM2_DRIVER_READBACK_EN.
module norm2_driver #(
  parameter int N = 1000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               in_valid,
  input  logic signed [26:0] in_data,
  output logic               in_ready,
  output logic               res_valid,
  output logic signed [63:0] res_data,
  input  logic               res_ready,
  output logic [31:0]        res_cycles,
  output logic               busy,
  output logic               chk_err,
  output logic               acc_controlArr,
  output logic               acc_wen,
  output logic [9:0]         acc_addr,
  output logic signed [26:0] acc_wdata,
  input  logic signed [26:0] acc_rdata,
  output logic               acc_r_enable,
  output logic [9:0]         acc_init_i,
  output logic signed [63:0] acc_init_acc,
  input  logic               acc_w_enable,
  input  logic signed [63:0] acc_result,
  output logic [2:0]         dbg_state
);

  // Handshakes: a beat moves when valid && ready are both high at a rising edge;
  // valid never depends on ready, and a presented result stays stable until taken.

  localparam logic [9:0] LAST = 10'(N - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
`ifdef NORM2_DRIVER_READBACK_EN
    S_VERIFY = 3'd2,
`endif
    S_START  = 3'd3,
    S_RUN    = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t             state_q, state_d;
  logic [9:0]         addr_q, addr_d;
  logic signed [63:0] res_data_q, res_data_d;
  logic [31:0]        cycles_q, cycles_d;
  logic               in_ready_q, in_ready_d;
  logic               busy_q, busy_d;
  logic               acc_ctrl_q, acc_ctrl_d;
  logic               r_en_q, r_en_d;
  logic               res_valid_q, res_valid_d;

`ifdef NORM2_DRIVER_READBACK_EN
  logic signed [36:0] wsum_q, wsum_d;
  logic signed [36:0] rsum_q, rsum_d;
  logic               issue_done_q, issue_done_d;
  logic               rd_vld_q, rd_vld_d;
  logic               rd_last_q, rd_last_d;
  logic               chk_err_q, chk_err_d;
`else
  logic unused_rdata;
  assign unused_rdata = ^acc_rdata;
`endif

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    res_data_d = res_data_q;
    cycles_d   = cycles_q;
    acc_wen    = 1'b0;
    acc_addr   = '0;
    acc_wdata  = '0;
`ifdef NORM2_DRIVER_READBACK_EN
    wsum_d       = wsum_q;
    rsum_d       = rsum_q;
    issue_done_d = issue_done_q;
    rd_vld_d     = 1'b0;
    rd_last_d    = 1'b0;
    chk_err_d    = chk_err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD;
          addr_d  = '0;
`ifdef NORM2_DRIVER_READBACK_EN
          wsum_d    = '0;
          chk_err_d = 1'b0;
`endif
        end
      end
      S_LOAD: begin
        acc_addr = addr_q;
        // in_ready is high for the whole of LOAD, so in_valid alone marks a transfer
        if (in_valid) begin
          acc_wen   = 1'b1;
          acc_wdata = in_data;
`ifdef NORM2_DRIVER_READBACK_EN
          wsum_d = wsum_q + 37'(in_data);
`endif
          if (addr_q == LAST) begin
            addr_d = '0;
`ifdef NORM2_DRIVER_READBACK_EN
            state_d      = S_VERIFY;
            rsum_d       = '0;
            issue_done_d = 1'b0;
`else
            state_d = S_START;
`endif
          end else begin
            addr_d = addr_q + 10'd1;
          end
        end
      end
`ifdef NORM2_DRIVER_READBACK_EN
      S_VERIFY: begin
        acc_addr  = addr_q;
        rd_vld_d  = !issue_done_q;
        rd_last_d = !issue_done_q && (addr_q == LAST);
        if (!issue_done_q) begin
          if (addr_q == LAST) begin
            issue_done_d = 1'b1;
            addr_d       = '0;
          end else begin
            addr_d = addr_q + 10'd1;
          end
        end
        // read data trails its address by one cycle
        if (rd_vld_q) begin
          rsum_d = rsum_q + 37'(acc_rdata);
          if (rd_last_q) begin
            if (rsum_d == wsum_q) begin
              state_d = S_START;
            end else begin
              state_d    = S_DONE;
              chk_err_d  = 1'b1;
              res_data_d = '0;
              cycles_d   = '0;
            end
          end
        end
      end
`endif
      S_START: begin
        cycles_d = '0;
        state_d  = S_RUN;
      end
      S_RUN: begin
        if (cycles_q != 32'hFFFF_FFFF) cycles_d = cycles_q + 32'd1;
        if (acc_w_enable) begin
          res_data_d = acc_result;
          state_d    = S_DONE;
        end
      end
      S_DONE: begin
        if (res_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    in_ready_d  = (state_d == S_LOAD);
    busy_d      = (state_d != S_IDLE);
    acc_ctrl_d  = !((state_d == S_START) || (state_d == S_RUN));
    r_en_d      = (state_d == S_START);
    res_valid_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      res_data_q  <= '0;
      cycles_q    <= '0;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      acc_ctrl_q  <= 1'b1;
      r_en_q      <= 1'b0;
      res_valid_q <= 1'b0;
`ifdef NORM2_DRIVER_READBACK_EN
      wsum_q       <= '0;
      rsum_q       <= '0;
      issue_done_q <= 1'b0;
      rd_vld_q     <= 1'b0;
      rd_last_q    <= 1'b0;
      chk_err_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      res_data_q  <= res_data_d;
      cycles_q    <= cycles_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
      acc_ctrl_q  <= acc_ctrl_d;
      r_en_q      <= r_en_d;
      res_valid_q <= res_valid_d;
`ifdef NORM2_DRIVER_READBACK_EN
      wsum_q       <= wsum_d;
      rsum_q       <= rsum_d;
      issue_done_q <= issue_done_d;
      rd_vld_q     <= rd_vld_d;
      rd_last_q    <= rd_last_d;
      chk_err_q    <= chk_err_d;
`endif
    end
  end

  assign in_ready       = in_ready_q;
  assign res_valid      = res_valid_q;
  assign res_data       = res_data_q;
  assign res_cycles     = cycles_q;
  assign busy           = busy_q;
  assign acc_controlArr = acc_ctrl_q;
  assign acc_r_enable   = r_en_q;
  assign acc_init_i     = '0;
  assign acc_init_acc   = '0;
  assign dbg_state      = state_q;
`ifdef NORM2_DRIVER_READBACK_EN
  assign chk_err = chk_err_q;
`else
  assign chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_norm2_driver.sv
// Bench for norm2_driver: directed jobs against a negedge-driven accelerator model and a
// per-cycle compare process; results are also pinned against hand-computed literals.
module tb_norm2_driver;
  localparam int N = 1000;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               start = 1'b0;
  logic               in_valid = 1'b0;
  logic signed [26:0] in_data = '0;
  logic               in_ready;
  logic               res_valid;
  logic signed [63:0] res_data;
  logic               res_ready = 1'b0;
  logic [31:0]        res_cycles;
  logic               busy;
  logic               chk_err;
  logic               acc_controlArr;
  logic               acc_wen;
  logic [9:0]         acc_addr;
  logic signed [26:0] acc_wdata;
  logic signed [26:0] acc_rdata = '0;
  logic               acc_r_enable;
  logic [9:0]         acc_init_i;
  logic signed [63:0] acc_init_acc;
  logic               acc_w_enable = 1'b0;
  logic signed [63:0] acc_result = '0;
  logic [2:0]         dbg_state;

  norm2_driver #(.N(N)) dut (
    .clk(clk), .rst(rst), .start(start),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .res_valid(res_valid), .res_data(res_data), .res_ready(res_ready),
    .res_cycles(res_cycles), .busy(busy), .chk_err(chk_err),
    .acc_controlArr(acc_controlArr), .acc_wen(acc_wen), .acc_addr(acc_addr),
    .acc_wdata(acc_wdata), .acc_rdata(acc_rdata),
    .acc_r_enable(acc_r_enable), .acc_init_i(acc_init_i), .acc_init_acc(acc_init_acc),
    .acc_w_enable(acc_w_enable), .acc_result(acc_result),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, $signed(got), got,
               $signed(exp), exp, $time);
    end
  endtask

  function automatic logic signed [26:0] gen_data(input int pat, input int i);
    case (pat)
      0:       return 27'sd1;
      1:       return -27'sd67108864;
      2:       return 27'((i * 37) % 201 - 100);
      3:       return 27'(i % 8);
      default: return 27'(i % 50 - 25);
    endcase
  endfunction

  // ---------------- accelerator model ----------------
  logic signed [26:0] mem [N];
  int                 acc_lat = 1;
  bit                 acc_square = 1'b1;
  bit                 corrupt = 1'b0;
  int                 acc_cnt = 0;
  bit                 armed = 1'b0;
  logic [9:0]         rd_pend_addr = '0;

  function automatic logic signed [63:0] acc_compute();
    logic signed [63:0] s;
    logic signed [63:0] v;
    s = 0;
    for (int i = 0; i < N; i++) begin
      v = mem[i];
      s = s + (acc_square ? v * v : v);
    end
    return s;
  endfunction

  initial for (int i = 0; i < N; i++) mem[i] = '0;

  always @(negedge clk) begin
    if (acc_wen && int'(acc_addr) < N)
      mem[acc_addr] = (corrupt && acc_addr == 10'd7) ? acc_wdata + 27'sd1 : acc_wdata;
    rd_pend_addr = acc_addr;
    acc_w_enable = 1'b0;
    if (acc_r_enable) begin
      armed   = 1'b1;
      acc_cnt = acc_lat;
    end else if (armed) begin
      acc_cnt--;
      if (acc_cnt == 0) begin
        armed        = 1'b0;
        acc_w_enable = 1'b1;
        acc_result   = acc_compute();
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (int'(rd_pend_addr) < N) acc_rdata = mem[rd_pend_addr];
  end

  // ---------------- reference model and compare ----------------
  bit                 mon_en = 1'b0;
  int                 cur_pat = 0;
  int                 wr_count = 0;
  int                 ren_count = 0;
  int                 res_count = 0;
  bit                 prev_accept = 1'b0;
  logic signed [63:0] exp_res = '0;
  logic [31:0]        exp_cycles = '0;
  logic               exp_err = 1'b0;

  always @(negedge clk) begin
    if (!rst && mon_en) begin
      if (in_valid && in_ready) begin
        chk("wr_bound", 64'(wr_count < N), 64'd1);
        chk("wen", 64'(acc_wen), 64'd1);
        chk("waddr", 64'(acc_addr), 64'(wr_count));
        chk("wdata", 64'(acc_wdata), 64'(gen_data(cur_pat, wr_count)));
        wr_count++;
      end else begin
        chk("wen_idle", 64'(acc_wen), 64'd0);
      end
      if (!busy) begin
        chk("idle_in_ready", 64'(in_ready), 64'd0);
        chk("idle_res_valid", 64'(res_valid), 64'd0);
        chk("idle_r_enable", 64'(acc_r_enable), 64'd0);
        chk("idle_ctrl", 64'(acc_controlArr), 64'd1);
      end
      if (acc_r_enable) begin
        chk("start_ctrl", 64'(acc_controlArr), 64'd0);
        chk("start_init", 64'(acc_init_i) | 64'(acc_init_acc), 64'd0);
        ren_count++;
      end
      if (prev_accept) chk("res_valid_drop", 64'(res_valid), 64'd0);
      if (res_valid) begin
        chk("res_data", 64'(res_data), 64'(exp_res));
        chk("res_cycles", 64'(res_cycles), 64'(exp_cycles));
        chk("chk_err", 64'(chk_err), 64'(exp_err));
        chk("done_ctrl", 64'(acc_controlArr), 64'd1);
      end
      prev_accept = res_valid && res_ready;
      if (prev_accept) res_count++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic job_setup(input int pat, input bit sq, input int lat, input bit corr);
    logic signed [63:0] v;
    cur_pat    = pat;
    acc_square = sq;
    acc_lat    = lat;
    corrupt    = corr;
    wr_count   = 0;
    ren_count  = 0;
    res_count  = 0;
    exp_res    = 0;
    for (int i = 0; i < N; i++) begin
      v       = gen_data(pat, i);
      exp_res = exp_res + (sq ? v * v : v);
    end
    exp_cycles = 32'(lat);
    exp_err    = 1'b0;
    if (corr) begin
      exp_res    = 0;
      exp_cycles = 0;
      exp_err    = 1'b1;
    end
  endtask

  // called just after a rising edge; returns just after a rising edge
  task automatic drive_load(input int pat, input int gap, input int stop_at);
    int idx = 0;
    int cyc = 0;
    bit hs;
    while (idx < stop_at && cyc < 4 * N + 100) begin
      in_valid = (gap == 0) || (cyc % 2 == 0);
      in_data  = gen_data(pat, idx);
      @(negedge clk);
      hs = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (hs) idx++;
      cyc++;
    end
    if (idx < stop_at) chk("load_timeout", 64'(idx), 64'(stop_at));
  endtask

  task automatic pulse_start(input int pat);
    in_valid = 1'b1;
    in_data  = gen_data(pat, 0);
    repeat (3) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic run_job(input string nm, input int pat, input bit sq, input int lat, input int gap,
                         input int rdy_wait, input bit start_in_run, input bit corr,
                         input bit use_lit, input logic signed [63:0] lit);
    int                 c;
    logic signed [63:0] got;
    logic [31:0]        got_cyc;
    job_setup(pat, sq, lat, corr);
    pulse_start(pat);
    drive_load(pat, gap, N);
    in_valid = 1'b0;
    if (start_in_run) begin
      c = 0;
      while (ren_count == 0 && c < 5000) begin
        @(negedge clk);
        c++;
      end
      repeat (3) @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
    end
    c = 0;
    @(negedge clk);
    while (!res_valid && c < 5000) begin
      @(negedge clk);
      c++;
    end
    chk({nm, "_res_timeout"}, 64'(res_valid), 64'd1);
    got     = res_data;
    got_cyc = res_cycles;
    repeat (rdy_wait) @(negedge clk);
    chk({nm, "_res_held"}, 64'(res_data), 64'(got));
    @(posedge clk);
    #1 res_ready = 1'b1;
    @(posedge clk);
    #1 res_ready = 1'b0;
    repeat (30) @(negedge clk);
    chk({nm, "_writes"}, 64'(wr_count), 64'(N));
    chk({nm, "_results"}, 64'(res_count), 64'd1);
    chk({nm, "_r_enables"}, 64'(ren_count), corr ? 64'd0 : 64'd1);
    chk({nm, "_idle"}, 64'(busy), 64'd0);
    chk({nm, "_cycles"}, 64'(got_cyc), corr ? 64'd0 : 64'(lat));
    if (use_lit) chk({nm, "_literal"}, 64'(got), 64'(lit));
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_res_valid", 64'(res_valid), 64'd0);
    chk("rst_res_data", 64'(res_data), 64'd0);
    chk("rst_res_cycles", 64'(res_cycles), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_chk_err", 64'(chk_err), 64'd0);
    chk("rst_ctrl", 64'(acc_controlArr), 64'd1);
    chk("rst_wen", 64'(acc_wen), 64'd0);
    chk("rst_r_enable", 64'(acc_r_enable), 64'd0);
    chk("rst_addr", 64'(acc_addr), 64'd0);
    chk("rst_wdata", 64'(acc_wdata), 64'd0);
    chk("rst_init", 64'(acc_init_i) | 64'(acc_init_acc), 64'd0);
    mon_en = 1'b1;
    @(posedge clk);
    #1;

    run_job("ones", 0, 1'b1, 5, 0, 3, 1'b0, 1'b0, 1'b1, 64'sd1000);
    run_job("minval", 1, 1'b1, 3, 0, 0, 1'b0, 1'b0, 1'b1, 64'sd4503599627370496000);
    run_job("toggle", 2, 1'b1, 7, 1, 10, 1'b0, 1'b0, 1'b0, 64'sd0);

    // abort a load halfway with reset, then run a full job over the stale array
    job_setup(2, 1'b1, 1, 1'b0);
    pulse_start(2);
    drive_load(2, 0, 500);
    chk("midrst_addr", 64'(acc_addr), 64'd500);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_wen", 64'(acc_wen), 64'd0);
    chk("midrst_ctrl", 64'(acc_controlArr), 64'd1);
    chk("midrst_in_ready", 64'(in_ready), 64'd0);
    chk("midrst_res_data", 64'(res_data), 64'd0);
    chk("midrst_res_cycles", 64'(res_cycles), 64'd0);
    @(posedge clk);
    #1;
    run_job("mod8", 3, 1'b0, 4, 0, 2, 1'b0, 1'b0, 1'b1, 64'sd3500);

    run_job("start_in_run", 4, 1'b1, 20, 0, 1, 1'b1, 1'b0, 1'b0, 64'sd0);

`ifdef NORM2_DRIVER_READBACK_EN
    run_job("corrupt", 3, 1'b1, 4, 0, 2, 1'b0, 1'b1, 1'b1, 64'sd0);
    chk("corrupt_err_held", 64'(chk_err), 64'd1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/norm2_driver.md
NORM2_DRIVER -- requirements
Module: norm2_driver

Interface
REQ-001 Parameter: N, default 1000, array depth and element count (1..1000).
REQ-002 Clock and reset: one clock; reset is synchronous and active-high.
REQ-003 clk  in  1  sole clock, rising edge.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 start  in  1  begin job; sampled only in IDLE.
REQ-006 in_valid  in  1  / in_data  in  27 signed  / in_ready  out  1  element stream, transfer when valid&&ready.
REQ-007 res_valid  out  1  / res_data  out  64 signed  / res_ready  in  1  result handshake.
REQ-008 res_cycles  out  32  RUN-phase cycle count of the last job.
REQ-009 busy  out  1  high in every state except IDLE.
REQ-010 chk_err  out  1  readback mismatch flag.
REQ-011 acc_controlArr  out  1; acc_wen  out  1; acc_addr  out  10; acc_wdata  out  27 signed; acc_rdata  in  27 signed  accelerator array port, read data valid one cycle after address.
REQ-012 acc_r_enable  out  1; acc_init_i  out  10; acc_init_acc  out  64 signed; acc_w_enable  in  1; acc_result  in  64 signed  accelerator start/done.

Function
REQ-013 States: IDLE, LOAD, VERIFY, START, RUN, DONE.
REQ-014 IDLE->LOAD on start; start outside IDLE ignored.
REQ-015 LOAD: in_ready=1; each transfer drives acc_wen=1, acc_addr=addr, acc_wdata=in_data in that cycle; addr increments 0..N-1; no transfer -> acc_wen=0, addr holds.
REQ-016 LOAD exits after the transfer at addr N-1: to VERIFY if READBACK_EN defined, else START.
REQ-017 acc_controlArr=1 in IDLE, LOAD, VERIFY, DONE; 0 in START and RUN.
REQ-018 START: one cycle, acc_r_enable=1, acc_init_i=0, acc_init_acc=0; then RUN.
REQ-019 RUN: res_cycles counter cleared on START, increments each RUN cycle, saturates at 0xFFFFFFFF.
REQ-020 RUN->DONE on first cycle acc_w_enable=1; res_data<=acc_result in that cycle.
REQ-021 DONE: res_valid=1, res_data and res_cycles stable until res_ready=1; then IDLE, res_valid=0 next cycle.
REQ-022 acc_r_enable is 0 in every state but START; acc_wen is 0 outside LOAD (and VERIFY).
REQ-023 No wrap-around: addr never exceeds N-1; in_valid outside LOAD ignored, data not consumed.

Reset
REQ-024 rst, in any state including mid-LOAD/RUN: next state IDLE; addr=0; in_ready=0, res_valid=0, res_data=0, res_cycles=0, busy=0, chk_err=0, acc_controlArr=1, acc_wen=0, acc_r_enable=0, acc_addr=0, acc_wdata=0, acc_init_i=0, acc_init_acc=0.
REQ-025 Array contents partially loaded before rst are not cleared; next job overwrites all N entries.

Configuration
REQ-026 Macro NORM2_DRIVER_READBACK_EN.
REQ-027 Defined: LOAD accumulates 37-bit signed sum of written data; VERIFY issues reads addr 0..N-1, one per cycle, acc_wen=0, accumulates acc_rdata one cycle later; after last data, equal sums -> START; unequal -> chk_err=1, res_data=0, res_cycles=0, go to DONE without START.
REQ-028 chk_err cleared on start acceptance and on rst.
REQ-029 Undefined: no VERIFY state, no checksum logic, chk_err tied 0.

Verification
REQ-030 N=1000, all in_data=1, model accelerator -> res_data=1000, res_valid held until res_ready.
REQ-031 All in_data=-67108864 -> res_data=4503599627370496000, no overflow.
REQ-032 in_valid toggled every other cycle -> acc_addr 0..999 contiguous, 1000 writes exactly; res_ready low 10 cycles in DONE -> res_data unchanged.
REQ-033 rst at addr 500 during LOAD -> next cycle busy=0, acc_wen=0, acc_controlArr=1; subsequent full job with in_data=i%8 returns 3500.
REQ-034 start pulsed during RUN -> ignored, single result returned; res_cycles equals model RUN latency.
REQ-035 READBACK_EN: model corrupts entry 7 after write -> chk_err=1, res_data=0, acc_r_enable never asserted.
